// File: rtl/defines_package.sv
// -----------------------------------------------------------------------------
// defines_package
//   Shared types for the scanline colorfill datapath.
//   `WIDTH / `HEIGHT : screen size in pixels / rows.
//   Vertex3D, Triangle3D: signed 16-bit vertex coordinates, three vertices.
//   Color              : 8-bit RGB fill colour.
//   sched_state_e      : fill_scheduler sequencer states.
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

package defines_package;

    localparam int SCR_ROWS = `HEIGHT;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D [2:0] v;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BOUND = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/ybound_clip.sv
// -----------------------------------------------------------------------------
// ybound_clip
//   Combinational vertical extent of a triangle, clipped to the screen.
//   y0..y2 : signed vertex y coordinates
//   ymin   : max(min(y), 0)                (valid when !empty)
//   ymax   : min(max(y), SCR_HEIGHT-1)     (valid when !empty)
//   empty  : no on-screen row is covered
// -----------------------------------------------------------------------------
module ybound_clip #(
    parameter int SCR_HEIGHT = 480
) (
    input  logic signed [15:0] y0,
    input  logic signed [15:0] y1,
    input  logic signed [15:0] y2,
    output logic signed [15:0] ymin,
    output logic signed [15:0] ymax,
    output logic               empty
);

    localparam logic signed [16:0] ROW_LAST = 17'(SCR_HEIGHT - 1);

    // Widened to 17 bits so the clip compares against SCR_HEIGHT-1 never wrap.
    logic signed [16:0] y0_w_s;
    logic signed [16:0] y1_w_s;
    logic signed [16:0] y2_w_s;
    logic signed [16:0] lo01_s;
    logic signed [16:0] hi01_s;
    logic signed [16:0] lo_raw_s;
    logic signed [16:0] hi_raw_s;
    logic signed [16:0] lo_clip_s;
    logic signed [16:0] hi_clip_s;

    assign y0_w_s = {y0[15], y0};
    assign y1_w_s = {y1[15], y1};
    assign y2_w_s = {y2[15], y2};

    assign lo01_s   = (y0_w_s < y1_w_s) ? y0_w_s : y1_w_s;
    assign hi01_s   = (y0_w_s > y1_w_s) ? y0_w_s : y1_w_s;
    assign lo_raw_s = (lo01_s < y2_w_s) ? lo01_s : y2_w_s;
    assign hi_raw_s = (hi01_s > y2_w_s) ? hi01_s : y2_w_s;

    assign lo_clip_s = (lo_raw_s < 17'sd0)   ? 17'sd0   : lo_raw_s;
    assign hi_clip_s = (hi_raw_s > ROW_LAST) ? ROW_LAST : hi_raw_s;

    assign empty = (hi_raw_s < 17'sd0) || (lo_raw_s > ROW_LAST) || (lo_clip_s > hi_clip_s);

    // Clipped values lie in 0..SCR_HEIGHT-1, so the low 16 bits are exact.
    assign ymin = lo_clip_s[15:0];
    assign ymax = hi_clip_s[15:0];

endmodule

// File: rtl/fill_scheduler.sv
// -----------------------------------------------------------------------------
// fill_scheduler
//   Row sequencer between triangle setup and the colorfill engine. Accepts a
//   triangle + colour, computes its clipped vertical extent, then launches
//   colorfill once per scanline (pulse fill_en, wait fill_done, advance).
//
//   Ports:
//     clk, n_rst             : clock; synchronous active-high reset
//     tri_valid / tri_ready  : upstream triangle handshake
//     tri_in, rgb_in         : triangle and fill colour from setup
//     fill_en, fill_height   : one-cycle start pulse and row to colorfill
//     fill_tri, fill_rgb     : latched triangle / colour to colorfill
//     fill_done              : colorfill row complete
//     tri_done               : one-cycle pulse, all rows finished
//     busy                   : high outside IDLE
//     rows_filled            : rows completed for current/last triangle
//     err_timeout            : sticky watchdog flag
//
//   Optional: FILL_SCHED_WATCHDOG_EN adds a per-row WAIT watchdog of TIMEOUT
//   cycles; without it err_timeout is tied low and WAIT holds indefinitely.
// -----------------------------------------------------------------------------
module fill_scheduler
    import defines_package::*;
#(
    parameter int SCR_HEIGHT = SCR_ROWS,
    parameter int TIMEOUT    = 2048
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  Triangle3D          tri_in,
    input  Color               rgb_in,
    output logic               fill_en,
    output logic signed [15:0] fill_height,
    output Triangle3D          fill_tri,
    output Color               fill_rgb,
    input  logic               fill_done,
    output logic               tri_done,
    output logic               busy,
    output logic [9:0]         rows_filled,
    output logic               err_timeout
);

    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_BOUND = 3'(BOUND);
    localparam logic [2:0] ST_ISSUE = 3'(ISSUE);
    localparam logic [2:0] ST_WAIT  = 3'(WAIT);
    localparam logic [2:0] ST_DONE  = 3'(DONE);

    logic [2:0]         state_r;
    logic               tri_ready_r;
    logic               fill_en_r;
    logic signed [15:0] fill_height_r;
    Triangle3D          fill_tri_r;
    Color               fill_rgb_r;
    logic               tri_done_r;
    logic               busy_r;
    logic [9:0]         rows_filled_r;
    logic signed [15:0] row_r;
    logic signed [15:0] ymax_r;

    logic signed [15:0] clip_ymin_s;
    logic signed [15:0] clip_ymax_s;
    logic               clip_empty_s;
    logic               row_last_s;
    logic signed [15:0] row_next_s;
    logic               wd_hit_s;

    // Bounds are taken from the latched triangle, which is stable during BOUND.
    ybound_clip #(
        .SCR_HEIGHT (SCR_HEIGHT)
    ) u_ybound_clip (
        .y0    (fill_tri_r.v[0].y),
        .y1    (fill_tri_r.v[1].y),
        .y2    (fill_tri_r.v[2].y),
        .ymin  (clip_ymin_s),
        .ymax  (clip_ymax_s),
        .empty (clip_empty_s)
    );

    assign row_last_s = (row_r == ymax_r);
    assign row_next_s = row_r + 16'sd1;

`ifdef FILL_SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt_r;
    logic        err_timeout_r;

    // The counter holds WD_LAST during the TIMEOUT-th WAIT cycle; fill_done wins.
    assign wd_hit_s = (state_r == ST_WAIT) && !fill_done && (wd_cnt_r == WD_LAST);

    // Per-row WAIT cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wd_cnt_r      <= 16'd0;
            err_timeout_r <= 1'b0;
        end else begin
            if (state_r == ST_ISSUE) begin
                wd_cnt_r <= 16'd0;
            end else if (state_r == ST_WAIT) begin
                wd_cnt_r <= wd_cnt_r + 16'd1;
            end
            if (wd_hit_s) begin
                err_timeout_r <= 1'b1;
            end
        end
    end

    assign err_timeout = err_timeout_r;
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = 32'(TIMEOUT);
    assign wd_hit_s         = 1'b0;
    assign err_timeout      = 1'b0;
`endif

    // Sequencer state, row bookkeeping and all registered handshake outputs
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_r       <= ST_IDLE;
            tri_ready_r   <= 1'b1;
            fill_en_r     <= 1'b0;
            fill_height_r <= 16'sd0;
            fill_tri_r    <= '0;
            fill_rgb_r    <= '0;
            tri_done_r    <= 1'b0;
            busy_r        <= 1'b0;
            rows_filled_r <= 10'd0;
            row_r         <= 16'sd0;
            ymax_r        <= 16'sd0;
        end else begin
            fill_en_r  <= 1'b0;
            tri_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tri_valid && tri_ready_r) begin
                        fill_tri_r    <= tri_in;
                        fill_rgb_r    <= rgb_in;
                        rows_filled_r <= 10'd0;
                        tri_ready_r   <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_BOUND;
                    end
                end
                ST_BOUND: begin
                    row_r  <= clip_ymin_s;
                    ymax_r <= clip_ymax_s;
                    if (clip_empty_s) begin
                        tri_done_r <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        fill_en_r     <= 1'b1;
                        fill_height_r <= clip_ymin_s;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A watchdog expiry ends the row like fill_done but is not counted.
                    if (fill_done || wd_hit_s) begin
                        if (fill_done) begin
                            rows_filled_r <= rows_filled_r + 10'd1;
                        end
                        if (row_last_s) begin
                            tri_done_r <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            row_r         <= row_next_s;
                            fill_en_r     <= 1'b1;
                            fill_height_r <= row_next_s;
                            state_r       <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    tri_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    tri_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign tri_ready   = tri_ready_r;
    assign fill_en     = fill_en_r;
    assign fill_height = fill_height_r;
    assign fill_tri    = fill_tri_r;
    assign fill_rgb    = fill_rgb_r;
    assign tri_done    = tri_done_r;
    assign busy        = busy_r;
    assign rows_filled = rows_filled_r;

endmodule
